mp3_stream_feeder: RTL and testbench

MP3_STREAM_FEEDER -- requirements
Module: mp3_stream_feeder

---
 rtl/mp3_stream_feeder_if.sv | 11 +
 rtl/mp3_stream_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_mp3_stream_feeder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp3_stream_feeder_if.sv
// Word stream from the feeder to the downstream SPI serialiser.
// The feeder drives data/last/valid; the serialiser answers with ready.
interface mp3_stream_feeder_if;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_data, word_last, word_valid, input word_ready);
    modport slave  (input word_data, word_last, word_valid, output word_ready);
endinterface

// File: rtl/mp3_stream_feeder.sv
// MP3 stream feeder: reads track words out of a block ROM and streams them
// into a small output FIFO that feeds the SPI serialiser.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no track active, nothing buffered or in flight
// FETCH | issuing ROM reads, limited by FIFO credit and pause
// DRAIN | all addresses issued, waiting for in-flight and buffered words
module mp3_stream_feeder #(
    parameter int          ROM_LAT    = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [14:0] T0_BASE    = 15'd0,
    parameter logic [14:0] T0_LEN     = 15'd22262,
    parameter logic [14:0] T1_BASE    = 15'd0,
    parameter logic [14:0] T1_LEN     = 15'd0,
    parameter logic [14:0] T2_BASE    = 15'd0,
    parameter logic [14:0] T2_LEN     = 15'd0,
    parameter logic [14:0] T3_BASE    = 15'd0,
    parameter logic [14:0] T3_LEN     = 15'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      play_req,
    input  logic [1:0]                track_sel,
    input  logic                      loop_en,
    input  logic                      pause,
    output logic [14:0]               rom_addr,
    input  logic [31:0]               rom_data,
    mp3_stream_feeder_if.master       word_if,
    output logic                      track_done,
    output logic                      busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [14:0]           addr_q, addr_d;
    logic [14:0]           remain_q, remain_d;
    logic [14:0]           base_q, base_d;
    logic [14:0]           len_q, len_d;
    logic [ROM_LAT-1:0]    vld_pipe_q, vld_pipe_d;
    logic [ROM_LAT-1:0]    last_pipe_q, last_pipe_d;
    logic [31:0]           mem_data_q [FIFO_DEPTH];
    logic [31:0]           mem_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q, mem_last_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic                  track_done_q, track_done_d;

    logic [14:0] sel_base;
    logic [14:0] sel_len;
    logic [5:0]  inflight;
    logic        fifo_empty;
    logic        word_valid;
    logic        head_last;
    logic        credit_ok;
    logic        issue;
    logic        push;
    logic        pop;

    // Track table lookup for the requested track.
    always_comb begin
        sel_base = T0_BASE;
        sel_len  = T0_LEN;
        case (track_sel)
            2'd1:    begin sel_base = T1_BASE; sel_len = T1_LEN; end
            2'd2:    begin sel_base = T2_BASE; sel_len = T2_LEN; end
            2'd3:    begin sel_base = T3_BASE; sel_len = T3_LEN; end
            default: begin sel_base = T0_BASE; sel_len = T0_LEN; end
        endcase
    end

    // Reads still travelling through the ROM pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + 6'(vld_pipe_q[i]);
        end
    end

    assign fifo_empty = (fifo_cnt_q == '0);
    assign word_valid = !fifo_empty && !pause;
    assign head_last  = mem_last_q[rd_ptr_q];
    assign pop        = word_valid && word_if.word_ready;
    // Counting in-flight reads as occupied slots guarantees every landing word has room.
    assign credit_ok  = (6'(fifo_cnt_q) + inflight) < 6'(FIFO_DEPTH);
    // A restart request suppresses this cycle's read and discards the word landing now.
    assign issue      = (state_q == FETCH) && !pause && !play_req && credit_ok;
    assign push       = vld_pipe_q[ROM_LAT-1] && !play_req;

    // Next-state logic for sequencing, ROM pipe and output FIFO.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        base_d       = base_q;
        len_d        = len_q;
        mem_data_d   = mem_data_q;
        mem_last_d   = mem_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        vld_pipe_d   = '0;
        last_pipe_d  = '0;

        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (remain_q == 15'd1);
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end

        if (push) begin
            mem_data_d[wr_ptr_q] = rom_data;
            mem_last_d[wr_ptr_q] = last_pipe_q[ROM_LAT-1];
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        // The pulse for a last word taken this cycle survives a simultaneous restart.
        track_done_d = (pop && head_last) || (play_req && (sel_len == '0));

        case (state_q)
            FETCH: begin
                if (issue) begin
                    addr_d   = addr_q + 15'd1;
                    remain_d = remain_q - 15'd1;
                    if (remain_q == 15'd1) begin
                        if (loop_en) begin
                            addr_d   = base_q;
                            remain_d = len_q;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && (inflight == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (play_req) begin
            vld_pipe_d  = '0;
            last_pipe_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
            if (sel_len == '0) begin
                state_d = IDLE;
            end else begin
                state_d  = FETCH;
                base_d   = sel_base;
                len_d    = sel_len;
                addr_d   = sel_base;
                remain_d = sel_len;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            base_q       <= '0;
            len_q        <= '0;
            vld_pipe_q   <= '0;
            last_pipe_q  <= '0;
            mem_last_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            track_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            base_q       <= base_d;
            len_q        <= len_d;
            vld_pipe_q   <= vld_pipe_d;
            last_pipe_q  <= last_pipe_d;
            mem_last_q   <= mem_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            track_done_q <= track_done_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign rom_addr           = addr_q;
    assign word_if.word_data  = mem_data_q[rd_ptr_q];
    assign word_if.word_last  = head_last;
    assign word_if.word_valid = word_valid;
    assign track_done         = track_done_q;
    assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_mp3_stream_feeder.sv
// Randomized bench for mp3_stream_feeder with a track-level reference model.
module tb_mp3_stream_feeder;
    localparam int          ROM_LAT    = 3;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [14:0] T0_BASE = 15'd0,     T0_LEN = 15'd22262;
    localparam logic [14:0] T1_BASE = 15'd100,   T1_LEN = 15'd3;
    localparam logic [14:0] T2_BASE = 15'h7fff,  T2_LEN = 15'd2;
    localparam logic [14:0] T3_BASE = 15'd500,   T3_LEN = 15'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        play_req;
    logic [1:0]  track_sel;
    logic        loop_en;
    logic        pause;
    logic        word_ready;
    logic [14:0] rom_addr;
    logic [31:0] rom_data;
    logic        track_done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mp3_stream_feeder_if wif();
    assign wif.word_ready = word_ready;

    mp3_stream_feeder #(
        .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH),
        .T0_BASE(T0_BASE), .T0_LEN(T0_LEN), .T1_BASE(T1_BASE), .T1_LEN(T1_LEN),
        .T2_BASE(T2_BASE), .T2_LEN(T2_LEN), .T3_BASE(T3_BASE), .T3_LEN(T3_LEN)
    ) dut (
        .clk(clk), .rst(rst), .play_req(play_req), .track_sel(track_sel),
        .loop_en(loop_en), .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data),
        .word_if(wif), .track_done(track_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [14:0] a);
        return {~a, 2'b01, a};
    endfunction

    function automatic logic [14:0] trk_base(input logic [1:0] t);
        case (t)
            2'd0: return T0_BASE;
            2'd1: return T1_BASE;
            2'd2: return T2_BASE;
            default: return T3_BASE;
        endcase
    endfunction

    function automatic logic [14:0] trk_len(input logic [1:0] t);
        case (t)
            2'd0: return T0_LEN;
            2'd1: return T1_LEN;
            2'd2: return T2_LEN;
            default: return T3_LEN;
        endcase
    endfunction

    // Block ROM: data for an address appears ROM_LAT cycles later.
    logic [14:0] addr_dly [ROM_LAT];
    always @(posedge clk) begin
        addr_dly[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) addr_dly[i] <= addr_dly[i-1];
    end
    assign rom_data = rom_fn(addr_dly[ROM_LAT-1]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [1:0] t);
        play_req  = 1'b1;
        track_sel = t;
        cyc();
        play_req  = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            cyc();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Reference model: which word of which track must come out next.
    bit          m_active = 1'b0;
    logic [14:0] m_base = '0;
    logic [14:0] m_len = '0;
    int          m_off = 0;
    bit          m_done_exp = 1'b0;
    bit          prev_pause = 1'b0;
    bit          prev_play = 1'b1;
    logic [14:0] prev_addr = '0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_active   = 1'b0;
            m_done_exp = 1'b0;
            prev_play  = 1'b1;
        end else begin
            chk("track_done", 32'(track_done), 32'(m_done_exp));
            if (track_done) done_cnt++;
            m_done_exp = 1'b0;
            if (pause) chk("valid_in_pause", 32'(wif.word_valid), 32'd0);
            if (prev_pause && !prev_play) chk("addr_hold_pause", 32'(rom_addr), 32'(prev_addr));
            if (m_active) chk("busy_active", 32'(busy), 32'd1);
            if (wif.word_valid && word_ready) begin
                if (!m_active) begin
                    chk("stray_word", 32'(wif.word_valid & word_ready), 32'd0);
                end else begin
                    chk("word_data", wif.word_data, rom_fn(m_base + 15'(m_off)));
                    chk("word_last", 32'(wif.word_last), 32'(m_off == int'(m_len) - 1));
                    if (m_off == int'(m_len) - 1) begin
                        m_done_exp = 1'b1;
                        if (loop_en) m_off = 0;
                        else m_active = 1'b0;
                    end else begin
                        m_off++;
                    end
                end
            end
            if (play_req) begin
                m_base = trk_base(track_sel);
                m_len  = trk_len(track_sel);
                m_off  = 0;
                m_active = (m_len != '0);
                if (m_len == '0) m_done_exp = 1'b1;
            end
            prev_play = play_req;
        end
        prev_pause = pause;
        prev_addr  = rom_addr;
    end

    initial begin
        int d0;
        int n;
        rst = 1'b1; play_req = 1'b0; track_sel = 2'd0;
        loop_en = 1'b0; pause = 1'b0; word_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(wif.word_valid), 32'd0);
        chk("rst_last", 32'(wif.word_last), 32'd0);
        chk("rst_data", wif.word_data, 32'd0);
        chk("rst_done", 32'(track_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();

        // zero-length track
        play(2'd3);
        chk("len0_done", 32'(track_done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_addr", 32'(rom_addr), 32'd0);
        cyc();

        // short track, addresses in order, single done pulse
        d0 = done_cnt;
        play(2'd1);
        chk("t1_addr0", 32'(rom_addr), 32'd100);
        cyc();
        chk("t1_addr1", 32'(rom_addr), 32'd101);
        cyc();
        chk("t1_addr2", 32'(rom_addr), 32'd102);
        wait_idle(40);
        cyc();
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // credit limit with the consumer stalled
        word_ready = 1'b0;
        play(2'd0);
        repeat (20) cyc();
        chk("credit_addr", 32'(rom_addr), 32'(T0_BASE + 15'(FIFO_DEPTH)));
        chk("stall_valid", 32'(wif.word_valid), 32'd1);
        word_ready = 1'b1;
        repeat (30) cyc();

        // pause mid-track
        repeat (6) cyc();
        pause = 1'b1;
        repeat (10) cyc();
        pause = 1'b0;
        #1;
        chk("resume_valid", 32'(wif.word_valid), 32'd1);
        repeat (20) cyc();

        // restart with three reads in flight
        play(2'd0);
        repeat (3) cyc();
        play(2'd2);
        wait_idle(40);

        // loop of a two-word track across the 15-bit wrap, ended by reset
        loop_en = 1'b1;
        d0 = done_cnt;
        play(2'd2);
        repeat (30) cyc();
        chk("loop_passes", 32'(done_cnt - d0 >= 5), 32'd1);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        loop_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_valid", 32'(wif.word_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            cyc();
        end

        // restart in the same cycle as the last word transfer
        play(2'd1);
        n = 0;
        while (!(wif.word_valid && wif.word_last) && n < 30) begin
            cyc();
            n++;
        end
        chk("last_seen", 32'(wif.word_valid & wif.word_last), 32'd1);
        play(2'd2);
        chk("restart_done", 32'(track_done), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_idle(40);

        // random episodes
        for (int ep = 0; ep < 16; ep++) begin
            int trk;
            int len_c;
            loop_en = ($urandom_range(0, 2) == 0);
            trk = int'($urandom_range(0, 3));
            play(trk[1:0]);
            len_c = int'($urandom_range(5, 60));
            for (int c = 0; c < len_c; c++) begin
                pause      = ($urandom_range(0, 4) == 0);
                word_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
        end

        loop_en = 1'b0; pause = 1'b0; word_ready = 1'b1;
        play(2'd1);
        wait_idle(60);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
